// File: rtl/debug_pkg.sv
// Shared types and constants for the debug stream controller.
package debug_pkg;

   // Controller states
   typedef enum logic [2:0] {
      ST_INIT     = 3'd0,
      ST_IDLE     = 3'd1,
      ST_GET_BP   = 3'd2,
      ST_CONT     = 3'd3,
      ST_STEP     = 3'd4,
      ST_STEP_RUN = 3'd5,
      ST_CAPTURE  = 3'd6,
      ST_SEND     = 3'd7
   } state_t;

   // Host command bytes received over the UART
   localparam logic [7:0] CMD_CONT    = 8'h63;  // 'c'
   localparam logic [7:0] CMD_STEP    = 8'h73;  // 's'
   localparam logic [7:0] CMD_NEXT    = 8'h6E;  // 'n'
   localparam logic [7:0] CMD_BREAK   = 8'h62;  // 'b'
   localparam logic [7:0] CMD_HALT    = 8'h68;  // 'h'
   localparam logic [7:0] CMD_RESTART = 8'h72;  // 'r'

   // First byte of every snapshot frame
   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/debug_stream_ctrl_if.sv
// UART FIFO handshake bundle between the debug controller and the FIFOs.
interface debug_stream_ctrl_if;
   logic [7:0] uartFifoDataIn;
   logic       uartDataAvailable;
   logic       txFull;
   logic       readFifoFlag;
   logic       writeFifoFlag;
   logic [7:0] dataToUartOutFifo;

   // Controller side
   modport master (
      input  uartFifoDataIn,
      input  uartDataAvailable,
      input  txFull,
      output readFifoFlag,
      output writeFifoFlag,
      output dataToUartOutFifo
   );

   // FIFO side
   modport slave (
      output uartFifoDataIn,
      output uartDataAvailable,
      output txFull,
      input  readFifoFlag,
      input  writeFifoFlag,
      input  dataToUartOutFifo
   );
endinterface

// File: rtl/debug_frame_serializer.sv
// Freezes a pipeline snapshot and streams it as header, little-endian
// data bytes and XOR checksum, one byte per accepted TX push.
module debug_frame_serializer
   import debug_pkg::*;
#(
   parameter int         NUM_WORDS = 24,
   parameter logic [7:0] HEADER    = DEFAULT_HEADER
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    i_start,
   input  logic                    i_send,
   input  logic [32*NUM_WORDS-1:0] i_snapshot,
   input  logic                    i_tx_full,
   output logic                    o_write,
   output logic [7:0]              o_data,
   output logic                    o_done
);

   localparam int NBYTES = 4 * NUM_WORDS;
   localparam int IDX_W  = $clog2(NBYTES + 2);
   localparam int SEL_W  = $clog2(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES + 1);

   logic [NBYTES-1:0][7:0] r_snap;
   logic [IDX_W-1:0]       r_idx;
   logic [7:0]             r_csum;
   logic [SEL_W-1:0]       w_sel;
   logic [7:0]             w_byte;
   logic                   w_push;

   // Index 1 maps to snapshot byte 0, which is word 0 lane 0
   assign w_sel  = SEL_W'(r_idx - IDX_W'(1));
   assign w_push = i_send && !i_tx_full;

   // Pick header, snapshot byte or checksum for the current index
   always_comb begin
      if (r_idx == '0) begin
         w_byte = HEADER;
      end else if (r_idx == LAST_IDX) begin
         w_byte = r_csum;
      end else begin
         w_byte = r_snap[w_sel];
      end
   end

   // Freeze snapshot on start; advance index and checksum only on accepted pushes
   always_ff @(posedge clock) begin
      if (reset) begin
         r_snap <= '0;
         r_idx  <= '0;
         r_csum <= '0;
      end else if (i_start) begin
         r_snap <= i_snapshot;
         r_idx  <= '0;
         r_csum <= '0;
      end else if (w_push) begin
         if (r_idx != '0 && r_idx != LAST_IDX) begin
            r_csum <= r_csum ^ w_byte;
         end
         if (r_idx != LAST_IDX) begin
            r_idx <= r_idx + IDX_W'(1);
         end
      end
   end

   assign o_write = w_push;
   assign o_data  = i_send ? w_byte : 8'h00;
   assign o_done  = w_push && (r_idx == LAST_IDX);

endmodule

// File: rtl/debug_stream_ctrl.sv
// Debug controller: runs, single-steps or breakpoints the datapath from
// UART commands and streams a snapshot frame after every stop.
module debug_stream_ctrl
   import debug_pkg::*;
#(
   parameter int         NUM_WORDS = 24,
   parameter int         PC_WIDTH  = 8,
   parameter logic [7:0] HEADER    = DEFAULT_HEADER
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    endOfProgram,
   input  logic [PC_WIDTH-1:0]     FE_pc,
   input  logic [32*NUM_WORDS-1:0] snapshot,
   debug_stream_ctrl_if.master     bus,
   output logic                    pipeEnable,
   output logic                    pipeReset,
   output logic                    ledIdle,
   output logic                    ledCont,
   output logic                    ledStep,
   output logic                    ledSend,
   output logic                    busy
);

   state_t              r_state;
   state_t              w_next;
   logic [PC_WIDTH-1:0] r_bp_pc;
   logic                r_bp_valid;
   logic                r_end_latch;
   logic                w_rd;
   logic                w_pipe_en;
   logic                w_bp_load;
   logic                w_bp_clr;
   logic                w_end_set;
   logic                w_end_clr;
   logic                w_start;
   logic                w_send;
   logic                w_done;
   logic                w_bp_hit;
   logic                w_halt;

   assign w_bp_hit = r_bp_valid && (FE_pc == r_bp_pc);
   assign w_halt   = bus.uartDataAvailable && (bus.uartFifoDataIn == CMD_HALT);
   // Reset kills pushes in the same cycle so an abandoned frame stops at once
   assign w_send   = (r_state == ST_SEND) && !reset;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_next;
      end
   end

   // Breakpoint register and end-of-program latch
   always_ff @(posedge clock) begin
      if (reset) begin
         r_bp_pc     <= '0;
         r_bp_valid  <= 1'b0;
         r_end_latch <= 1'b0;
      end else begin
         if (w_bp_load) begin
            r_bp_pc    <= bus.uartFifoDataIn[PC_WIDTH-1:0];
            r_bp_valid <= 1'b1;
         end else if (w_bp_clr) begin
            r_bp_valid <= 1'b0;
         end
         if (w_end_set) begin
            r_end_latch <= 1'b1;
         end else if (w_end_clr) begin
            r_end_latch <= 1'b0;
         end
      end
   end

   // Next state, RX pop, pipeline enable and flag updates
   always_comb begin
      w_next    = r_state;
      w_rd      = 1'b0;
      w_pipe_en = 1'b0;
      w_bp_load = 1'b0;
      w_bp_clr  = 1'b0;
      w_end_set = 1'b0;
      w_end_clr = 1'b0;
      w_start   = 1'b0;
      if (!reset) begin
         case (r_state)
            ST_INIT: w_next = ST_IDLE;
            ST_IDLE: begin
               if (bus.uartDataAvailable) begin
                  w_rd = 1'b1;
                  if (bus.uartFifoDataIn == CMD_CONT) w_next = ST_CONT;
                  else if (bus.uartFifoDataIn == CMD_STEP) w_next = ST_STEP;
                  else if (bus.uartFifoDataIn == CMD_BREAK) w_next = ST_GET_BP;
               end
            end
            ST_GET_BP: begin
               if (bus.uartDataAvailable) begin
                  w_rd      = 1'b1;
                  w_bp_load = 1'b1;
                  w_next    = ST_CONT;
               end
            end
            ST_CONT: begin
               // Every RX byte is drained here; only 'h' stops the run
               w_rd = bus.uartDataAvailable;
               if (endOfProgram || w_bp_hit || w_halt) begin
                  w_end_set = endOfProgram;
                  w_bp_clr  = w_bp_hit;
                  w_next    = ST_CAPTURE;
               end else begin
                  w_pipe_en = 1'b1;
               end
            end
            ST_STEP: begin
               if (bus.uartDataAvailable) begin
                  w_rd = 1'b1;
                  if (bus.uartFifoDataIn == CMD_NEXT) w_next = ST_STEP_RUN;
                  else if (bus.uartFifoDataIn == CMD_CONT) w_next = ST_CONT;
                  else if (bus.uartFifoDataIn == CMD_RESTART) w_next = ST_IDLE;
               end
            end
            ST_STEP_RUN: begin
               w_pipe_en = 1'b1;
               w_end_set = endOfProgram;
               w_next    = ST_CAPTURE;
            end
            ST_CAPTURE: begin
               w_start = 1'b1;
               w_next  = ST_SEND;
            end
            ST_SEND: begin
               if (w_done) begin
                  if (r_end_latch) begin
                     w_end_clr = 1'b1;
                     w_next    = ST_IDLE;
                  end else begin
                     w_next = ST_STEP;
                  end
               end
            end
            default: w_next = ST_INIT;
         endcase
      end
   end

   debug_frame_serializer #(
      .NUM_WORDS (NUM_WORDS),
      .HEADER    (HEADER)
   ) u_serializer (
      .clock      (clock),
      .reset      (reset),
      .i_start    (w_start),
      .i_send     (w_send),
      .i_snapshot (snapshot),
      .i_tx_full  (bus.txFull),
      .o_write    (bus.writeFifoFlag),
      .o_data     (bus.dataToUartOutFifo),
      .o_done     (w_done)
   );

   assign bus.readFifoFlag = w_rd;
   assign pipeEnable       = w_pipe_en;
   assign pipeReset        = (r_state == ST_INIT) || (r_state == ST_IDLE) || (r_state == ST_GET_BP);
   assign ledIdle          = (r_state == ST_IDLE);
   assign ledCont          = (r_state == ST_CONT);
   assign ledStep          = (r_state == ST_STEP);
   assign ledSend          = (r_state == ST_SEND);
   assign busy             = (r_state == ST_SEND);

endmodule

// File: doc/debug_stream_ctrl.md
# debug_stream_ctrl

Parametrised debug controller between the UART FIFOs and the pipelined datapath. It runs the pipeline continuously, single-steps it, or runs it to a PC breakpoint. After each step, breakpoint hit, host halt or program end, it captures a snapshot of NUM_WORDS 32-bit pipeline words and streams it to the UART TX FIFO. Each frame is a header byte, the data bytes in little-endian order, and an XOR checksum, and frames respect TX back-pressure.

## Interface
Parameters:
- NUM_WORDS, 24, number of 32-bit snapshot words (1..60)
- PC_WIDTH, 8, width of FE_pc and breakpoint register (1..8)
- HEADER, 8'hA5, first byte of every frame

Ports:
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- endOfProgram  in  1  datapath reached end of program
- FE_pc  in  PC_WIDTH  fetch-stage PC
- snapshot  in  32*NUM_WORDS  pipeline state, word k = bits [32k+31:32k]
- uartFifoDataIn  in  8  RX FIFO head byte (first-word-fall-through)
- uartDataAvailable  in  1  RX FIFO non-empty
- txFull  in  1  TX FIFO full
- readFifoFlag  out  1  pop RX FIFO this cycle
- writeFifoFlag  out  1  push dataToUartOutFifo this cycle
- dataToUartOutFifo  out  8  TX byte
- pipeEnable  out  1  advance datapath this cycle
- pipeReset  out  1  hold datapath in reset
- ledIdle, ledCont, ledStep, ledSend  out  1 each  one-hot state indication
- busy  out  1  frame transmission in progress

## Operation
- States: INIT, IDLE, GET_BP, CONT, STEP, STEP_RUN, CAPTURE, SEND.
- INIT: pipeReset=1. Goes to IDLE after one cycle.
- IDLE: pipeReset=1, ledIdle=1. When uartDataAvailable=1, readFifoFlag=1 and the byte is consumed:
  - 'c'(0x63) → CONT
  - 's'(0x73) → STEP
  - 'b'(0x62) → GET_BP
  - any other byte is discarded; stay in IDLE.
- GET_BP: pipeReset=1. The next byte is consumed, its low PC_WIDTH bits load bpPc, bpValid is set, and the state goes to CONT.
- CONT: ledCont=1. Each cycle, pipeEnable=1 unless a stop condition holds. The stop conditions, each → CAPTURE with pipeEnable=0 that cycle:
  - endOfProgram=1: set endLatch.
  - bpValid and FE_pc==bpPc: clear bpValid.
  - Host 'h'(0x68) consumed (readFifoFlag=1).
  - Other RX bytes in CONT are consumed and ignored.
- STEP: ledStep=1, pipeEnable=0. Consumed byte:
  - 'n'(0x6E) → STEP_RUN
  - 'c' → CONT
  - 'r'(0x72) → IDLE
  - any other byte is ignored.
- STEP_RUN: pipeEnable=1 for exactly one cycle. Sets endLatch if endOfProgram=1. → CAPTURE.
- CAPTURE: one cycle. The snapshot register loads snapshot, byte index=0, checksum=0. → SEND.
- SEND: ledSend=1, busy=1, no RX reads.
  - Byte index i runs 0..4*NUM_WORDS+1.
  - i=0 sends HEADER.
  - i=1..4*NUM_WORDS sends byte (i-1): word (i-1)/4, byte lane (i-1)%4, LSB lane first.
  - The last index sends the checksum, the XOR of all data bytes (header excluded).
  - writeFifoFlag = !txFull. i and the checksum advance only on an accepted push.
- SEND exit, after the checksum push: endLatch → clear endLatch, go to IDLE; otherwise → STEP.
- pipeReset=0 in CONT, STEP, STEP_RUN, CAPTURE and SEND.
- Index width is clog2(4*NUM_WORDS+2). The index never wraps; it clears in CAPTURE.

## Timing
- All outputs except readFifoFlag/writeFifoFlag/dataToUartOutFifo/pipeEnable are decoded from registered state.
- readFifoFlag, writeFifoFlag and pipeEnable are combinational from state plus uartDataAvailable/txFull/endOfProgram/FE_pc.
- Reset values, held while reset=1 and in INIT:
  - pipeReset=1
  - all other outputs 0
  - dataToUartOutFifo=0
  - bpValid, endLatch, snapshot register, index and checksum all 0.
- Latency:
  - 'n' consumed at cycle t: pipeEnable at t+1, capture at t+2, first push earliest at t+3.
  - Frame length is 4*NUM_WORDS+2 pushes, i.e. 4*NUM_WORDS+2 cycles with txFull=0.
- txFull stalls SEND indefinitely with no byte lost or duplicated. dataToUartOutFifo is held stable while stalled.
- Simultaneous stop conditions in CONT take priority endOfProgram > breakpoint > 'h'. All flags set by a simultaneous endOfProgram are still applied.
- Reset asserted mid-frame: INIT on the next edge. The partial frame is abandoned with no further pushes.
- The snapshot is frozen at CAPTURE, so datapath changes during SEND do not alter the frame.

## Structure
- Shared package debug_pkg:
  - state enum
  - command constants CMD_CONT, CMD_STEP, CMD_NEXT, CMD_BREAK, CMD_HALT, CMD_RESTART
  - default HEADER.
- Sub-module debug_frame_serializer: snapshot register, byte index, lane mux, checksum and TX handshake, with start/done ports.
- The top level holds the FSM, the breakpoint register and endLatch.

## Test plan
- Reset, then 's','n' with snapshot words k=0x01020304+k, NUM_WORDS=2, txFull=0:
  - exactly one pipeEnable pulse
  - frame A5 04 03 02 01 05 03 02 01, checksum 0x01
  - return to STEP.
- 'b',0x10,'c' with FE_pc counting from 0: pipeEnable high for 16 cycles, stop at FE_pc=0x10, one frame sent, state STEP, bpValid=0.
- 'c' then endOfProgram pulsed: one frame is sent, and ledIdle=1 and pipeReset=1 afterwards.
- txFull toggling every other cycle during SEND: 4*NUM_WORDS+2 accepted pushes, byte order identical to the txFull=0 case.
- Garbage bytes 0x41, 0x00 in IDLE: each gets a single-cycle readFifoFlag, state stays IDLE, no pipeEnable.
- Reset asserted at data byte index 5: the next cycle has writeFifoFlag=0 and pipeReset=1, and no pushes occur until a new command.
